// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Read data returned with rsp_err when a read response never arrives.
  localparam logic [31:0] ERR_RDATA = 32'h0BAD_0BAD;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way requester picker: round-robin on ties, or port 0 always wins.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       fixed_prio,
  output logic       sel
);

  // A single valid port always wins; a tie goes to port 0 or to the port not served last.
  always_comb begin
    sel = PORT_CORE;
    case (valid)
      2'b01:   sel = PORT_CORE;
      2'b10:   sel = PORT_DBG;
      2'b11:   sel = fixed_prio ? PORT_CORE : ~last;
      default: sel = PORT_CORE;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the core LSU (port 0) and the
// debug/loader (port 1). One read outstanding, with a response timeout.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | arbitrate and present the selected request to memory
//   WAIT  | read issued; waiting for mem_rvalid or the timeout
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_we,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             req_ready,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   core_stall,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                lock_q, lock_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                rst_q;
  logic                active;
  logic                pick;
  logic                sel;

  // Outputs stay quiet during reset and the first cycle after it.
  assign active = ~(rst | rst_q);

  rr_arb2 u_pick (
    .valid      (req_valid),
    .last       (last_q),
    .fixed_prio (FIXED_PRIO != 0),
    .sel        (pick)
  );

  // A request stalled by mem_gnt=0 keeps its port until accepted.
  assign sel = lock_q ? owner_q : pick;

  // State, arbitration history and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= PORT_CORE;
      last_q  <= PORT_DBG;
      lock_q  <= 1'b0;
      tcnt_q  <= '0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      tcnt_q  <= tcnt_d;
      rst_q   <= 1'b0;
    end
  end

  // Next-state logic plus request muxing and response generation.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    lock_d    = lock_q;
    tcnt_d    = tcnt_q;
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (active) begin
      case (state_q)
        IDLE: begin
          if (req_valid[sel]) begin
            mem_req   = 1'b1;
            mem_we    = req_we[sel];
            mem_addr  = req_addr[sel];
            mem_wdata = req_wdata[sel];
            if (mem_gnt) begin
              req_ready[sel] = 1'b1;
              last_d         = sel;
              lock_d         = 1'b0;
              if (!req_we[sel]) begin
                owner_d = sel;
                tcnt_d  = '0;
                state_d = WAIT;
              end
            end else begin
              lock_d  = 1'b1;
              owner_d = sel;
            end
          end
        end
        WAIT: begin
          tcnt_d = tcnt_q + TCNT_W'(1);
          if (mem_rvalid) begin
            rsp_valid[owner_q] = 1'b1;
            rsp_rdata          = mem_rdata;
            state_d            = IDLE;
          end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
            rsp_valid[owner_q] = 1'b1;
            rsp_rdata          = DATA_W'(ERR_RDATA);
            rsp_err            = 1'b1;
            state_d            = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign core_stall = active & req_valid[PORT_CORE] & ~req_ready[PORT_CORE];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance and a fixed-priority
// instance share the same stimulus; each scenario checks one of them.
module tb_dmem_arbiter;

  logic              clk;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_we;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  logic [1:0]  r_req_ready, r_rsp_valid, f_req_ready, f_rsp_valid;
  logic [31:0] r_rsp_rdata, r_mem_addr, r_mem_wdata, f_rsp_rdata, f_mem_addr, f_mem_wdata;
  logic        r_rsp_err, r_core_stall, r_mem_req, r_mem_we;
  logic        f_rsp_err, f_core_stall, f_mem_req, f_mem_we;

  int n_cmp = 0;
  int n_bad = 0;
  logic watch_fp = 1'b0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT(4)) u_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(r_req_ready),
    .rsp_valid(r_rsp_valid), .rsp_rdata(r_rsp_rdata), .rsp_err(r_rsp_err),
    .core_stall(r_core_stall), .mem_req(r_mem_req), .mem_we(r_mem_we),
    .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT(4)) u_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(f_req_ready),
    .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .rsp_err(f_rsp_err),
    .core_stall(f_core_stall), .mem_req(f_mem_req), .mem_we(f_mem_we),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester hold rule: a pending request must stay stable until accepted.
  logic [1:0]       p_valid, p_ready, p_we;
  logic [1:0][31:0] p_addr, p_wdata;
  logic             p_rst;
  always @(posedge clk) begin
    if (!rst && p_rst === 1'b0) begin
      for (int i = 0; i < 2; i++) begin
        if (p_valid[i] && !p_ready[i]) begin
          assert (req_valid[i] && req_we[i] == p_we[i] && req_addr[i] == p_addr[i] &&
                  req_wdata[i] == p_wdata[i])
            else $error("requester hold rule broken on port %0d", i);
        end
      end
    end
    p_rst   <= rst;
    p_valid <= req_valid;
    p_ready <= watch_fp ? f_req_ready : r_req_ready;
    p_we    <= req_we;
    p_addr  <= req_addr;
    p_wdata <= req_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic fp);
    rst = 1'b1; watch_fp = fp;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; req_we = 2'b11;
    req_addr[0] = 32'h10; req_addr[1] = 32'h20; req_wdata = '0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555;
    tick();
    n_cmp++; if (r_mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %b exp 0", r_mem_req); end
    n_cmp++; if (r_req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_ready: got %b exp 00", r_req_ready); end
    n_cmp++; if (r_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rst_rsp_valid: got %b exp 00", r_rsp_valid); end
    n_cmp++; if (r_core_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b exp 0", r_core_stall); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (r_mem_req !== 1'b0) begin n_bad++; $display("FAIL post_rst_mem_req: got %b exp 0", r_mem_req); end
    n_cmp++; if (r_req_ready !== 2'b00) begin n_bad++; $display("FAIL post_rst_ready: got %b exp 00", r_req_ready); end
    n_cmp++; if (r_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL post_rst_rsp_valid: got %b exp 00", r_rsp_valid); end
    n_cmp++; if (r_core_stall !== 1'b0) begin n_bad++; $display("FAIL post_rst_stall: got %b exp 0", r_core_stall); end
    tick();
    mem_rvalid = 1'b0;
    #1;
    n_cmp++; if (r_req_ready !== 2'b01) begin n_bad++; $display("FAIL first_tie_ready: got %b exp 01", r_req_ready); end
    n_cmp++; if (r_mem_addr !== 32'h10) begin n_bad++; $display("FAIL first_tie_addr: got %h exp 00000010", r_mem_addr); end
    n_cmp++; if (r_mem_we !== 1'b1) begin n_bad++; $display("FAIL first_tie_we: got %b exp 1", r_mem_we); end
    tick();
    req_valid = 2'b10;
    #1;
    n_cmp++; if (r_req_ready !== 2'b10) begin n_bad++; $display("FAIL second_ready: got %b exp 10", r_req_ready); end
    n_cmp++; if (r_mem_addr !== 32'h20) begin n_bad++; $display("FAIL second_addr: got %h exp 00000020", r_mem_addr); end
    tick();
  endtask

  task automatic test_preload();
    do_reset(1'b0);
    req_valid = 2'b10; req_we = 2'b10; req_addr[1] = 32'h4; req_wdata[1] = 32'hDEADBEEF; mem_gnt = 1'b1;
    #1;
    n_cmp++; if (r_req_ready !== 2'b10) begin n_bad++; $display("FAIL pre_wr_ready: got %b exp 10", r_req_ready); end
    n_cmp++; if (r_mem_we !== 1'b1) begin n_bad++; $display("FAIL pre_wr_we: got %b exp 1", r_mem_we); end
    n_cmp++; if (r_mem_addr !== 32'h4) begin n_bad++; $display("FAIL pre_wr_addr: got %h exp 00000004", r_mem_addr); end
    n_cmp++; if (r_mem_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL pre_wr_wdata: got %h exp deadbeef", r_mem_wdata); end
    n_cmp++; if (r_core_stall !== 1'b0) begin n_bad++; $display("FAIL pre_wr_stall: got %b exp 0", r_core_stall); end
    tick();
    req_we = 2'b00;
    #1;
    n_cmp++; if (r_req_ready !== 2'b10) begin n_bad++; $display("FAIL pre_rd_ready: got %b exp 10", r_req_ready); end
    n_cmp++; if (r_mem_we !== 1'b0) begin n_bad++; $display("FAIL pre_rd_we: got %b exp 0", r_mem_we); end
    tick();
    req_valid = 2'b00; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (r_rsp_valid !== 2'b10) begin n_bad++; $display("FAIL pre_rsp_valid: got %b exp 10", r_rsp_valid); end
    n_cmp++; if (r_rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL pre_rsp_rdata: got %h exp deadbeef", r_rsp_rdata); end
    n_cmp++; if (r_rsp_err !== 1'b0) begin n_bad++; $display("FAIL pre_rsp_err: got %b exp 0", r_rsp_err); end
    n_cmp++; if (r_mem_req !== 1'b0) begin n_bad++; $display("FAIL pre_wait_mem_req: got %b exp 0", r_mem_req); end
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy;
    logic [31:0] exp_addr;
    do_reset(1'b0);
    req_valid = 2'b11; req_we = 2'b00; req_addr[0] = 32'h100; req_addr[1] = 32'h200;
    for (int k = 0; k < 4; k++) begin
      exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 32'h100 : 32'h200;
      mem_gnt = 1'b1; mem_rvalid = 1'b0;
      #1;
      n_cmp++; if (r_req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_ready[%0d]: got %b exp %b", k, r_req_ready, exp_rdy); end
      n_cmp++; if (r_mem_addr !== exp_addr) begin n_bad++; $display("FAIL rr_addr[%0d]: got %h exp %h", k, r_mem_addr, exp_addr); end
      n_cmp++; if (r_core_stall !== exp_rdy[1]) begin n_bad++; $display("FAIL rr_issue_stall[%0d]: got %b exp %b", k, r_core_stall, exp_rdy[1]); end
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1000 + k;
      #1;
      n_cmp++; if (r_rsp_valid !== exp_rdy) begin n_bad++; $display("FAIL rr_rsp_valid[%0d]: got %b exp %b", k, r_rsp_valid, exp_rdy); end
      n_cmp++; if (r_rsp_rdata !== 32'h1000 + k) begin n_bad++; $display("FAIL rr_rsp_rdata[%0d]: got %h exp %h", k, r_rsp_rdata, 32'h1000 + k); end
      n_cmp++; if (r_core_stall !== 1'b1) begin n_bad++; $display("FAIL rr_wait_stall[%0d]: got %b exp 1", k, r_core_stall); end
      tick();
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_fixed_prio();
    do_reset(1'b1);
    req_valid = 2'b11; req_we = 2'b11; req_addr[1] = 32'h3F0; req_wdata[1] = 32'hAA; mem_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_addr[0] = 32'h300 + 4 * k;
      #1;
      n_cmp++; if (f_req_ready !== 2'b01) begin n_bad++; $display("FAIL fp_ready[%0d]: got %b exp 01", k, f_req_ready); end
      n_cmp++; if (f_mem_addr !== 32'h300 + 4 * k) begin n_bad++; $display("FAIL fp_addr[%0d]: got %h exp %h", k, f_mem_addr, 32'h300 + 4 * k); end
      n_cmp++; if (f_core_stall !== 1'b0) begin n_bad++; $display("FAIL fp_stall[%0d]: got %b exp 0", k, f_core_stall); end
      tick();
    end
    req_valid = 2'b10;
    #1;
    n_cmp++; if (f_req_ready !== 2'b10) begin n_bad++; $display("FAIL fp_dbg_ready: got %b exp 10", f_req_ready); end
    n_cmp++; if (f_mem_addr !== 32'h3F0) begin n_bad++; $display("FAIL fp_dbg_addr: got %h exp 000003f0", f_mem_addr); end
    tick();
  endtask

  task automatic test_lock();
    do_reset(1'b0);
    req_valid = 2'b10; req_we = 2'b11; req_addr[0] = 32'h40; req_addr[1] = 32'h44; mem_gnt = 1'b0;
    #1;
    n_cmp++; if (r_mem_addr !== 32'h44) begin n_bad++; $display("FAIL lock_c1_addr: got %h exp 00000044", r_mem_addr); end
    n_cmp++; if (r_req_ready !== 2'b00) begin n_bad++; $display("FAIL lock_c1_ready: got %b exp 00", r_req_ready); end
    tick();
    req_valid = 2'b11;
    #1;
    n_cmp++; if (r_mem_addr !== 32'h44) begin n_bad++; $display("FAIL lock_c2_addr: got %h exp 00000044", r_mem_addr); end
    n_cmp++; if (r_req_ready !== 2'b00) begin n_bad++; $display("FAIL lock_c2_ready: got %b exp 00", r_req_ready); end
    n_cmp++; if (r_core_stall !== 1'b1) begin n_bad++; $display("FAIL lock_c2_stall: got %b exp 1", r_core_stall); end
    tick();
    #1;
    n_cmp++; if (r_mem_addr !== 32'h44) begin n_bad++; $display("FAIL lock_c3_addr: got %h exp 00000044", r_mem_addr); end
    tick();
    mem_gnt = 1'b1;
    #1;
    n_cmp++; if (r_req_ready !== 2'b10) begin n_bad++; $display("FAIL lock_gnt_ready: got %b exp 10", r_req_ready); end
    n_cmp++; if (r_mem_addr !== 32'h44) begin n_bad++; $display("FAIL lock_gnt_addr: got %h exp 00000044", r_mem_addr); end
    tick();
    req_valid = 2'b01;
    #1;
    n_cmp++; if (r_req_ready !== 2'b01) begin n_bad++; $display("FAIL lock_next_ready: got %b exp 01", r_req_ready); end
    n_cmp++; if (r_mem_addr !== 32'h40) begin n_bad++; $display("FAIL lock_next_addr: got %h exp 00000040", r_mem_addr); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    req_valid = 2'b01; req_we = 2'b01; mem_gnt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_addr[0] = 32'h80 + 4 * k; req_wdata[0] = 32'hC0 + k;
      #1;
      n_cmp++; if (r_req_ready !== 2'b01) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b exp 01", k, r_req_ready); end
      n_cmp++; if (r_mem_wdata !== 32'hC0 + k) begin n_bad++; $display("FAIL b2b_wdata[%0d]: got %h exp %h", k, r_mem_wdata, 32'hC0 + k); end
      n_cmp++; if (r_mem_req !== 1'b1) begin n_bad++; $display("FAIL b2b_mem_req[%0d]: got %b exp 1", k, r_mem_req); end
      tick();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_timeout();
    do_reset(1'b0);
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 32'h50; mem_gnt = 1'b1;
    #1;
    n_cmp++; if (r_req_ready !== 2'b01) begin n_bad++; $display("FAIL to_issue_ready: got %b exp 01", r_req_ready); end
    tick();
    req_valid = 2'b00; mem_gnt = 1'b0;
    for (int w = 1; w < 4; w++) begin
      #1;
      n_cmp++; if (r_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL to_wait_rsp[%0d]: got %b exp 00", w, r_rsp_valid); end
      tick();
    end
    #1;
    n_cmp++; if (r_rsp_valid !== 2'b01) begin n_bad++; $display("FAIL to_rsp_valid: got %b exp 01", r_rsp_valid); end
    n_cmp++; if (r_rsp_rdata !== 32'h0BAD0BAD) begin n_bad++; $display("FAIL to_rsp_rdata: got %h exp 0bad0bad", r_rsp_rdata); end
    n_cmp++; if (r_rsp_err !== 1'b1) begin n_bad++; $display("FAIL to_rsp_err: got %b exp 1", r_rsp_err); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    #1;
    n_cmp++; if (r_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL late_rsp_valid: got %b exp 00", r_rsp_valid); end
    n_cmp++; if (r_rsp_err !== 1'b0) begin n_bad++; $display("FAIL late_rsp_err: got %b exp 0", r_rsp_err); end
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    do_reset(1'b0);
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 32'h60; mem_gnt = 1'b1;
    #1;
    n_cmp++; if (r_req_ready !== 2'b01) begin n_bad++; $display("FAIL rw_issue_ready: got %b exp 01", r_req_ready); end
    tick();
    req_valid = 2'b00; mem_gnt = 1'b0; rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    #1;
    n_cmp++; if (r_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rw_rst_rsp: got %b exp 00", r_rsp_valid); end
    n_cmp++; if (r_rsp_err !== 1'b0) begin n_bad++; $display("FAIL rw_rst_err: got %b exp 0", r_rsp_err); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (r_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rw_after_rsp: got %b exp 00", r_rsp_valid); end
    n_cmp++; if (r_mem_req !== 1'b0) begin n_bad++; $display("FAIL rw_after_mem_req: got %b exp 0", r_mem_req); end
    tick();
    mem_rvalid = 1'b0; req_valid = 2'b01; req_addr[0] = 32'h64; mem_gnt = 1'b1;
    #1;
    n_cmp++; if (r_req_ready !== 2'b01) begin n_bad++; $display("FAIL rw_next_ready: got %b exp 01", r_req_ready); end
    n_cmp++; if (r_mem_addr !== 32'h64) begin n_bad++; $display("FAIL rw_next_addr: got %h exp 00000064", r_mem_addr); end
    tick();
    req_valid = 2'b00; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99;
    #1;
    n_cmp++; if (r_rsp_valid !== 2'b01) begin n_bad++; $display("FAIL rw_next_rsp: got %b exp 01", r_rsp_valid); end
    n_cmp++; if (r_rsp_rdata !== 32'h99) begin n_bad++; $display("FAIL rw_next_rdata: got %h exp 00000099", r_rsp_rdata); end
    n_cmp++; if (r_rsp_err !== 1'b0) begin n_bad++; $display("FAIL rw_next_err: got %b exp 0", r_rsp_err); end
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_preload();
    test_round_robin();
    test_fixed_prio();
    test_lock();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
